mux_chan_scan: RTL and testbench

//  Parametrised NUM_CH:1 channel selector, DATA_W bits per channel, registered output with valid/ready.
//  Two modes: DIRECT (one transfer per accepted select request) and SCAN (round-robin over enabled channels).

---
 rtl/mux_chan_scan.sv | 124 ++++++++++++
 tb/tb_mux_chan_scan.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mux_chan_scan.sv
// NUM_CH:1 channel selector with a registered, channel-tagged output and a valid/ready handshake.
// DIRECT mode serves one select request per transfer; SCAN mode round-robins over enabled channels.
module mux_chan_scan #(
    parameter  int NUM_CH = 16,
    parameter  int DATA_W = 1,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_CH*DATA_W-1:0] i_in_data,
    input  logic                     i_mode,
    input  logic [NUM_CH-1:0]        i_ch_en,
    input  logic [SEL_W-1:0]         i_sel,
    input  logic                     i_sel_valid,
    output logic                     o_sel_ready,
    output logic [DATA_W-1:0]        o_out_data,
    output logic [SEL_W-1:0]         o_out_ch,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic                     o_sel_err
);

    typedef enum logic [1:0] {ST_IDLE, ST_DIRECT, ST_SCAN} state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_out_data;
    logic [SEL_W-1:0]    r_out_ch;
    logic [SEL_W-1:0]    r_scan_ptr;
    logic                r_out_valid;
    logic                r_sel_err;

    logic                w_can_load;
    logic                w_accept;
    logic                w_sel_bad;
    logic                w_found;
    logic [SEL_W-1:0]    w_nxt;
    logic [DATA_W-1:0]   w_sel_data;
    logic [DATA_W-1:0]   w_nxt_data;

    assign w_can_load  = !r_out_valid || i_out_ready;
    assign o_sel_ready = (r_state == ST_DIRECT) && w_can_load;
    assign w_accept    = i_sel_valid && o_sel_ready;
    // Only reachable when NUM_CH is not a power of two.
    assign w_sel_bad   = ({1'b0, i_sel} >= (SEL_W+1)'(NUM_CH));

    // An out-of-range select matches no channel, so its data reads as zero.
    always_comb begin
        w_sel_data = '0;
        w_nxt_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (i_sel == SEL_W'(k)) w_sel_data = i_in_data[k*DATA_W +: DATA_W];
            if (w_nxt == SEL_W'(k)) w_nxt_data = i_in_data[k*DATA_W +: DATA_W];
        end
    end

    // Walk offsets from farthest to nearest so the nearest enabled channel after
    // the pointer wins; offset NUM_CH lands back on the pointer itself.
    always_comb begin
        logic [SEL_W:0] v_sum;
        v_sum   = '0;
        w_found = 1'b0;
        w_nxt   = r_scan_ptr;
        for (int i = NUM_CH; i >= 1; i--) begin
            v_sum = {1'b0, r_scan_ptr} + (SEL_W+1)'(i);
            if (v_sum >= (SEL_W+1)'(NUM_CH)) v_sum = v_sum - (SEL_W+1)'(NUM_CH);
            if (i_ch_en[v_sum[SEL_W-1:0]]) begin
                w_found = 1'b1;
                w_nxt   = v_sum[SEL_W-1:0];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
            r_sel_err   <= 1'b0;
            r_scan_ptr  <= '0;
        end else begin
            r_sel_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_state <= i_mode ? ST_SCAN : ST_DIRECT;
                end
                ST_DIRECT: begin
                    if (w_accept) begin
                        r_out_data  <= w_sel_bad ? '0 : w_sel_data;
                        r_out_ch    <= i_sel;
                        r_out_valid <= 1'b1;
                        r_sel_err   <= w_sel_bad;
                    end else if (w_can_load) begin
                        r_out_valid <= 1'b0;
                    end
                    if (i_mode) begin
                        r_state    <= ST_SCAN;
                        r_scan_ptr <= SEL_W'(NUM_CH - 1);
                    end
                end
                ST_SCAN: begin
                    if (w_can_load) begin
                        if (w_found) begin
                            r_out_data  <= w_nxt_data;
                            r_out_ch    <= w_nxt;
                            r_out_valid <= 1'b1;
                            r_scan_ptr  <= w_nxt;
                        end else begin
                            r_out_valid <= 1'b0;
                        end
                    end
                    if (!i_mode) r_state <= ST_DIRECT;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_out_data  = r_out_data;
    assign o_out_ch    = r_out_ch;
    assign o_out_valid = r_out_valid;
    assign o_sel_err   = r_sel_err;

endmodule

// File: tb/tb_mux_chan_scan.sv
// Directed bench for mux_chan_scan: a 16x8 instance for DIRECT/SCAN/reset and
// a 12x8 instance for the out-of-range select.
module tb_mux_chan_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    // 16-channel instance
    logic [127:0] a_in;
    logic         a_mode, a_sel_valid, a_sel_ready, a_out_valid, a_out_ready, a_sel_err;
    logic [15:0]  a_ch_en;
    logic [3:0]   a_sel, a_out_ch;
    logic [7:0]   a_out_data;
    // 12-channel instance
    logic [95:0]  b_in;
    logic         b_mode, b_sel_valid, b_sel_ready, b_out_valid, b_out_ready, b_sel_err;
    logic [11:0]  b_ch_en;
    logic [3:0]   b_sel, b_out_ch;
    logic [7:0]   b_out_data;

    int n_chk = 0;
    int n_bad = 0;

    mux_chan_scan #(.NUM_CH(16), .DATA_W(8)) u_a (
        .i_clk(clk), .i_rst(rst), .i_in_data(a_in), .i_mode(a_mode), .i_ch_en(a_ch_en),
        .i_sel(a_sel), .i_sel_valid(a_sel_valid), .o_sel_ready(a_sel_ready),
        .o_out_data(a_out_data), .o_out_ch(a_out_ch), .o_out_valid(a_out_valid),
        .i_out_ready(a_out_ready), .o_sel_err(a_sel_err)
    );

    mux_chan_scan #(.NUM_CH(12), .DATA_W(8)) u_b (
        .i_clk(clk), .i_rst(rst), .i_in_data(b_in), .i_mode(b_mode), .i_ch_en(b_ch_en),
        .i_sel(b_sel), .i_sel_valid(b_sel_valid), .o_sel_ready(b_sel_ready),
        .o_out_data(b_out_data), .o_out_ch(b_out_ch), .o_out_valid(b_out_valid),
        .i_out_ready(b_out_ready), .o_sel_err(b_sel_err)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic [3:0] ch, input logic vld);
        chk({tag, ".ch"},   32'(a_out_ch),    32'(ch));
        chk({tag, ".data"}, 32'(a_out_data),  vld ? 32'(ch) + 32'h10 : 32'(a_out_data));
        chk({tag, ".vld"},  32'(a_out_valid), 32'(vld));
    endtask

    initial begin
        int scan_exp [6] = '{0, 2, 5, 0, 2, 5};
        for (int k = 0; k < 16; k++) a_in[k*8 +: 8] = 8'(k + 16);
        for (int k = 0; k < 12; k++) b_in[k*8 +: 8] = 8'(k + 16);
        rst = 1'b1;
        a_mode = 1'b0; a_ch_en = '0; a_sel = '0; a_sel_valid = 1'b0; a_out_ready = 1'b1;
        b_mode = 1'b0; b_ch_en = '0; b_sel = '0; b_sel_valid = 1'b0; b_out_ready = 1'b1;
        step(); step();

        chk("rst.vld",  32'(a_out_valid), 0);
        chk("rst.data", 32'(a_out_data),  0);
        chk("rst.ch",   32'(a_out_ch),    0);
        chk("rst.err",  32'(a_sel_err),   0);
        chk("rst.rdy",  32'(a_sel_ready), 0);

        rst = 1'b0;
        step();                              // IDLE -> DIRECT
        a_sel = 4'd5; a_sel_valid = 1'b1; #1;
        chk("dir.rdy", 32'(a_sel_ready), 1);
        step();
        a_sel_valid = 1'b0;
        chk_a("dir.sel5", 4'd5, 1'b1);
        chk("dir.err", 32'(a_sel_err), 0);

        // Backpressure: word 5 must hold while a new request waits.
        a_out_ready = 1'b0; a_sel = 4'd9; a_sel_valid = 1'b1; #1;
        chk("bp.rdy0", 32'(a_sel_ready), 0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk_a("bp.hold", 4'd5, 1'b1);
        end
        a_out_ready = 1'b1; #1;
        chk("bp.rdy1", 32'(a_sel_ready), 1);
        step();
        a_sel_valid = 1'b0;
        chk_a("bp.sel9", 4'd9, 1'b1);
        step();
        chk("dir.drain", 32'(a_out_valid), 0);

        // SCAN entered from DIRECT starts searching at channel 0.
        a_ch_en = 16'h0025; a_mode = 1'b1;
        step();
        a_sel_valid = 1'b1; #1;
        chk("scan.rdy", 32'(a_sel_ready), 0);
        for (int c = 0; c < 6; c++) begin
            step();
            chk_a($sformatf("scan.%0d", c), 4'(scan_exp[c]), 1'b1);
            chk("scan.err", 32'(a_sel_err), 0);
        end
        a_sel_valid = 1'b0;

        // Empty mask drains the held word, then idles.
        a_ch_en = '0;
        step();
        chk("empty.vld0", 32'(a_out_valid), 0);
        step();
        chk("empty.vld1", 32'(a_out_valid), 0);
        a_ch_en = 16'h8000;
        for (int c = 0; c < 3; c++) begin
            step();
            chk_a("only15", 4'd15, 1'b1);
        end

        // Mode switches while a word is held leave it untouched.
        a_out_ready = 1'b0;
        a_in[15*8 +: 8] = 8'hAA;
        step();
        a_in[15*8 +: 8] = 8'h1F;
        chk_a("hold.scan", 4'd15, 1'b1);
        a_mode = 1'b0;
        step();
        chk_a("hold.todir", 4'd15, 1'b1);
        a_mode = 1'b1;
        step();
        chk_a("hold.toscan", 4'd15, 1'b1);

        // Reset discards the held word.
        rst = 1'b1;
        step();
        chk("rst2.vld",  32'(a_out_valid), 0);
        chk("rst2.data", 32'(a_out_data),  0);
        chk("rst2.ch",   32'(a_out_ch),    0);
        rst = 1'b0; a_mode = 1'b0; a_ch_en = 16'h0025; a_out_ready = 1'b1;
        step();                              // IDLE -> DIRECT
        a_mode = 1'b1;
        step();                              // DIRECT -> SCAN
        step();
        chk_a("resume.0", 4'd0, 1'b1);
        step();
        chk_a("resume.2", 4'd2, 1'b1);

        // 12-channel instance: good select, then out-of-range select.
        b_sel = 4'd11; b_sel_valid = 1'b1; #1;
        chk("b.rdy", 32'(b_sel_ready), 1);
        step();
        chk("b.data11", 32'(b_out_data), 32'h1B);
        chk("b.ch11",   32'(b_out_ch),   11);
        chk("b.err11",  32'(b_sel_err),  0);
        b_sel = 4'd13;
        step();
        b_sel_valid = 1'b0;
        chk("b.data13", 32'(b_out_data),  0);
        chk("b.ch13",   32'(b_out_ch),    13);
        chk("b.vld13",  32'(b_out_valid), 1);
        chk("b.err13",  32'(b_sel_err),   1);
        step();
        chk("b.errclr", 32'(b_sel_err),   0);
        chk("b.vldclr", 32'(b_out_valid), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
